operand_stack_buffer: RTL and testbench

//  Parametrised successor to the single-operand calculator buffer: holds a DEPTH-entry LIFO of

---
 rtl/opbuf_pkg.sv | 21 ++
 rtl/opbuf_lifo.sv | 92 +++++++++
 rtl/operand_stack_buffer.sv | 182 ++++++++++++++++++
 tb/tb_operand_stack_buffer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/opbuf_pkg.sv
// opbuf_pkg
//   Shared definitions for the operand stack buffer and its LIFO.
//   - disp_mode_t     : what the seven-segment display is currently showing
//   - opbuf_operand_t : sign-magnitude operand at the default width
//                       (MSB = sign, lower bits = magnitude)
//   - OPBUF_SIGN_BIT  : bit index of the sign at the default width
//   Modules that take a WIDTH parameter build vectors of WIDTH+1 bits with
//   the same layout. The sign is always the top bit.
package opbuf_pkg;

  localparam int OPBUF_DEF_WIDTH = 8;
  localparam int OPBUF_SIGN_BIT  = OPBUF_DEF_WIDTH;

  typedef logic [OPBUF_SIGN_BIT:0] opbuf_operand_t;

  typedef enum logic {
    SHOW_ENTRY  = 1'b0,
    SHOW_RESULT = 1'b1
  } disp_mode_t;

endpackage

// File: rtl/opbuf_lifo.sv
// opbuf_lifo
//   Register-file LIFO of DEPTH sign-magnitude operands.
//   Entry 0 is the bottom of the stack. Entry count-1 is the top.
// Ports
//   i_clk        rising-edge clock
//   i_nrst       asynchronous active-low reset; clears storage and count
//   i_flush      drop all entries (highest priority)
//   i_push       write i_din above the current top; ignored when full
//   i_pop2_push  replace the two topmost entries with i_din;
//                ignored when fewer than two entries are held
//   i_din        operand to write
//   o_top        top entry, 0 when empty
//   o_second     entry below the top, 0 when fewer than two entries
//   o_count      number of valid entries
//   o_full       o_count == DEPTH
//   o_empty      o_count == 0
module opbuf_lifo
  import opbuf_pkg::*;
#(
  parameter int WIDTH = OPBUF_DEF_WIDTH,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop2_push,
  input  logic [WIDTH:0]   i_din,
  output logic [WIDTH:0]   o_top,
  output logic [WIDTH:0]   o_second,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty
);

  logic [WIDTH:0]  r_mem [DEPTH];
  logic [CW-1:0]   r_count;
  logic            w_full;
  logic            w_has_two;

  assign w_full    = (r_count == CW'(DEPTH));
  assign w_has_two = (r_count >= CW'(2));

  // Slot selection compares against an int copy of the count.
  // This keeps i+2 from wrapping when DEPTH+1 is a power of two.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_flush) begin
      r_count <= '0;
    end else if (i_push && !w_full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(r_count) == i) begin
          r_mem[i] <= i_din;
        end
      end
      r_count <= r_count + 1'b1;
    end else if (i_pop2_push && w_has_two) begin
      // The result overwrites the lower of the two consumed operands.
      for (int i = 0; i < DEPTH; i++) begin
        if (int'(r_count) == i + 2) begin
          r_mem[i] <= i_din;
        end
      end
      r_count <= r_count - 1'b1;
    end
  end

  // Stale slots above the count are masked, so flush never has to
  // clear the storage itself.
  always_comb begin
    o_top    = '0;
    o_second = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(r_count) == i + 1) begin
        o_top = r_mem[i];
      end
      if (int'(r_count) == i + 2) begin
        o_second = r_mem[i];
      end
    end
  end

  assign o_count = r_count;
  assign o_full  = w_full;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/operand_stack_buffer.sv
// operand_stack_buffer
//   Holds the calculator operands: a working entry register fed by the keypad,
//   a DEPTH-deep LIFO of sign-magnitude operands for the ALU, and the value
//   shown on the seven-segment display.
//
//   Events are decoded in the priority order clear > store_digit > enter >
//   result_ready. Lower-priority events in the same cycle are dropped.
//
//   Optional feature macro: OPBUF_RESULT_PUSH_EN
//     defined   : an ALU result replaces its two operands on the stack
//                 (RPN chaining)
//     undefined : an ALU result empties the stack and is only displayed
// Ports
//   i_clk, i_nrst          clock and asynchronous active-low reset
//   i_clear                flush stack, entry, display and error flag
//   i_store_digit, i_digit load a keypad value into the entry register
//   i_enter                push the entry register onto the stack
//   i_result_ready         single-cycle ALU result strobe
//   i_result               ALU result
//   o_op_a, o_op_b         top and second stack entries for the ALU
//   o_count                stack entry count
//   o_full, o_empty        stack status
//   o_ssdec, o_sign        display magnitude and sign
//   o_err                  sticky overflow/underflow flag
module operand_stack_buffer
  import opbuf_pkg::*;
#(
  parameter int WIDTH = OPBUF_DEF_WIDTH,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_clear,
  input  logic             i_store_digit,
  input  logic [WIDTH:0]   i_digit,
  input  logic             i_enter,
  input  logic             i_result_ready,
  input  logic [WIDTH:0]   i_result,
  output logic [WIDTH:0]   o_op_a,
  output logic [WIDTH:0]   o_op_b,
  output logic [CW-1:0]    o_count,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_ssdec,
  output logic             o_sign,
  output logic             o_err
);

  logic             w_do_clear;
  logic             w_do_store;
  logic             w_do_enter;
  logic             w_do_result;

  logic             w_lifo_flush;
  logic             w_lifo_push;
  logic             w_lifo_pop2_push;
  logic [WIDTH:0]   w_lifo_din;
  logic [CW-1:0]    w_count;
  logic             w_full;
  logic             w_few_operands;

  logic [WIDTH:0]   r_entry;
  logic [WIDTH-1:0] r_ssdec;
  logic             r_sign;
  logic             r_err;
  disp_mode_t       r_mode;

  logic [WIDTH:0]   w_entry_next;
  logic [WIDTH-1:0] w_ssdec_next;
  logic             w_sign_next;
  logic             w_err_next;
  disp_mode_t       w_mode_next;

  // One-hot event decode in priority order.
  assign w_do_clear  = i_clear;
  assign w_do_store  = !i_clear && i_store_digit;
  assign w_do_enter  = !i_clear && !i_store_digit && i_enter;
  assign w_do_result = !i_clear && !i_store_digit && !i_enter && i_result_ready;

  assign w_few_operands = (w_count < CW'(2));

`ifdef OPBUF_RESULT_PUSH_EN
  assign w_lifo_flush     = w_do_clear;
  assign w_lifo_pop2_push = w_do_result;
`else
  // Without chaining, any result consumes the whole stack.
  assign w_lifo_flush     = w_do_clear || w_do_result;
  assign w_lifo_pop2_push = 1'b0;
`endif

  assign w_lifo_push = w_do_enter;
  assign w_lifo_din  = w_do_result ? i_result : r_entry;

  opbuf_lifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_lifo (
    .i_clk       (i_clk),
    .i_nrst      (i_nrst),
    .i_flush     (w_lifo_flush),
    .i_push      (w_lifo_push),
    .i_pop2_push (w_lifo_pop2_push),
    .i_din       (w_lifo_din),
    .o_top       (o_op_a),
    .o_second    (o_op_b),
    .o_count     (w_count),
    .o_full      (w_full),
    .o_empty     (o_empty)
  );

  // Display mode register.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_mode <= SHOW_ENTRY;
    end else begin
      r_mode <= w_mode_next;
    end
  end

  // Next-state logic for the display mode, entry, display value and error flag.
  // A rejected push onto a full stack only raises err.
  // The display keeps whatever it was showing.
  always_comb begin
    w_mode_next  = r_mode;
    w_entry_next = r_entry;
    w_ssdec_next = r_ssdec;
    w_sign_next  = r_sign;
    w_err_next   = r_err;
    if (w_do_clear) begin
      w_mode_next  = SHOW_ENTRY;
      w_entry_next = '0;
      w_ssdec_next = '0;
      w_sign_next  = 1'b0;
      w_err_next   = 1'b0;
    end else if (w_do_store) begin
      w_mode_next  = SHOW_ENTRY;
      w_entry_next = i_digit;
      w_ssdec_next = i_digit[WIDTH-1:0];
      w_sign_next  = i_digit[WIDTH];
    end else if (w_do_enter) begin
      w_mode_next = SHOW_ENTRY;
      if (w_full) begin
        w_err_next = 1'b1;
      end else begin
        w_entry_next = '0;
        w_ssdec_next = '0;
        w_sign_next  = 1'b0;
      end
    end else if (w_do_result) begin
      w_mode_next  = SHOW_RESULT;
      w_ssdec_next = i_result[WIDTH-1:0];
      w_sign_next  = i_result[WIDTH];
      if (w_few_operands) begin
        w_err_next = 1'b1;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_entry <= '0;
      r_ssdec <= '0;
      r_sign  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_entry <= w_entry_next;
      r_ssdec <= w_ssdec_next;
      r_sign  <= w_sign_next;
      r_err   <= w_err_next;
    end
  end

  assign o_count = w_count;
  assign o_full  = w_full;
  assign o_ssdec = r_ssdec;
  assign o_sign  = r_sign;
  assign o_err   = r_err;

endmodule

// File: tb/tb_operand_stack_buffer.sv
// tb_operand_stack_buffer
//   Directed scoreboard bench for operand_stack_buffer (WIDTH=8, DEPTH=4).
//   The stimulus process queues a hand-computed output snapshot after each event.
//   A monitor pops and compares the snapshots on falling clock edges.
//   Expected values follow OPBUF_RESULT_PUSH_EN when it is defined.
module tb_operand_stack_buffer;
  import opbuf_pkg::*;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             clear = 1'b0;
  logic             storeDigit = 1'b0;
  logic [WIDTH:0]   digit = '0;
  logic             enter = 1'b0;
  logic             resultReady = 1'b0;
  logic [WIDTH:0]   result = '0;
  logic [WIDTH:0]   opA;
  logic [WIDTH:0]   opB;
  logic [CW-1:0]    count;
  logic             full;
  logic             empty;
  logic [WIDTH-1:0] ssdec;
  logic             sign;
  logic             err;

  typedef struct packed {
    opbuf_operand_t   opA;
    opbuf_operand_t   opB;
    logic [CW-1:0]    cnt;
    logic             full;
    logic             empty;
    logic [WIDTH-1:0] ssdec;
    logic             sign;
    logic             err;
  } snap_t;

  snap_t expQ[$];
  string nameQ[$];
  int    checkCount = 0;
  int    passCount = 0;
  snap_t monExp;
  string monName;

  always #5 clk = ~clk;

  operand_stack_buffer #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .i_clk          (clk),
    .i_nrst         (nrst),
    .i_clear        (clear),
    .i_store_digit  (storeDigit),
    .i_digit        (digit),
    .i_enter        (enter),
    .i_result_ready (resultReady),
    .i_result       (result),
    .o_op_a         (opA),
    .o_op_b         (opB),
    .o_count        (count),
    .o_full         (full),
    .o_empty        (empty),
    .o_ssdec        (ssdec),
    .o_sign         (sign),
    .o_err          (err)
  );

  // Compare the live DUT outputs against one expected snapshot.
  task automatic compareSnap(input string name, input snap_t exp);
    snap_t act;
    act = '{opA: opA, opB: opB, cnt: count, full: full, empty: empty,
            ssdec: ssdec, sign: sign, err: err};
    checkCount++;
    if (act === exp) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got opA=%h opB=%h cnt=%0d full=%b empty=%b ssdec=%h sign=%b err=%b, want opA=%h opB=%h cnt=%0d full=%b empty=%b ssdec=%h sign=%b err=%b",
               name, act.opA, act.opB, act.cnt, act.full, act.empty, act.ssdec, act.sign, act.err,
               exp.opA, exp.opB, exp.cnt, exp.full, exp.empty, exp.ssdec, exp.sign, exp.err);
    end
  endtask

  // Monitor: compare one queued expectation per falling edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp  = expQ.pop_front();
      monName = nameQ.pop_front();
      compareSnap(monName, monExp);
    end
  end

  // Drive one cycle of events. Inputs are released just after the capturing edge.
  task automatic applyStimulus(input logic clr, input logic st, input logic [WIDTH:0] dig,
                               input logic ent, input logic rr, input logic [WIDTH:0] res);
    @(negedge clk);
    clear       = clr;
    storeDigit  = st;
    digit       = dig;
    enter       = ent;
    resultReady = rr;
    result      = res;
    @(posedge clk);
    #1;
    clear       = 1'b0;
    storeDigit  = 1'b0;
    digit       = '0;
    enter       = 1'b0;
    resultReady = 1'b0;
    result      = '0;
  endtask

  // Queue the expected output snapshot for the cycle just driven.
  task automatic checkOutput(input string name, input logic [WIDTH:0] eA, input logic [WIDTH:0] eB,
                             input logic [CW-1:0] eCnt, input logic eFull, input logic eEmpty,
                             input logic [WIDTH-1:0] eSsdec, input logic eSign, input logic eErr);
    snap_t s;
    s = '{opA: eA, opB: eB, cnt: eCnt, full: eFull, empty: eEmpty,
          ssdec: eSsdec, sign: eSign, err: eErr};
    expQ.push_back(s);
    nameQ.push_back(name);
  endtask

  initial begin
    snap_t zeroSnap;
    zeroSnap = '{opA: '0, opB: '0, cnt: '0, full: 1'b0, empty: 1'b1,
                 ssdec: '0, sign: 1'b0, err: 1'b0};

    repeat (2) @(negedge clk);
    nrst = 1'b1;
    applyStimulus(0, 0, 9'h000, 0, 0, 9'h000);
    checkOutput("reset_state", 9'h000, 9'h000, 0, 0, 1, 8'h00, 0, 0);

    // Entry load, push, clear
    applyStimulus(0, 1, 9'h105, 0, 0, 9'h000);
    checkOutput("t1_store_neg5", 9'h000, 9'h000, 0, 0, 1, 8'h05, 1, 0);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    checkOutput("t1_enter", 9'h105, 9'h000, 1, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 0, 9'h000, 0, 0, 9'h000);
    checkOutput("t1_clear", 9'h000, 9'h000, 0, 0, 1, 8'h00, 0, 0);

    // Fill to full, then overflow
    applyStimulus(0, 1, 9'h003, 0, 0, 9'h000);
    checkOutput("t2_store3", 9'h000, 9'h000, 0, 0, 1, 8'h03, 0, 0);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    checkOutput("t2_push3", 9'h003, 9'h000, 1, 0, 0, 8'h00, 0, 0);
    applyStimulus(0, 1, 9'h007, 0, 0, 9'h000);
    checkOutput("t2_store7", 9'h003, 9'h000, 1, 0, 0, 8'h07, 0, 0);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    checkOutput("t2_push7", 9'h007, 9'h003, 2, 0, 0, 8'h00, 0, 0);
    applyStimulus(0, 1, 9'h002, 0, 0, 9'h000);
    checkOutput("t2_store2", 9'h007, 9'h003, 2, 0, 0, 8'h02, 0, 0);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    checkOutput("t2_push2", 9'h002, 9'h007, 3, 0, 0, 8'h00, 0, 0);
    applyStimulus(0, 1, 9'h009, 0, 0, 9'h000);
    checkOutput("t2_store9", 9'h002, 9'h007, 3, 0, 0, 8'h09, 0, 0);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    checkOutput("t2_push9_full", 9'h009, 9'h002, 4, 1, 0, 8'h00, 0, 0);
    applyStimulus(0, 1, 9'h005, 0, 0, 9'h000);
    checkOutput("t2_store5", 9'h009, 9'h002, 4, 1, 0, 8'h05, 0, 0);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    checkOutput("t2_overflow", 9'h009, 9'h002, 4, 1, 0, 8'h05, 0, 1);
    applyStimulus(1, 0, 9'h000, 0, 0, 9'h000);
    checkOutput("t2_clear", 9'h000, 9'h000, 0, 0, 1, 8'h00, 0, 0);

    // ALU result with two operands
    applyStimulus(0, 1, 9'h003, 0, 0, 9'h000);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    applyStimulus(0, 1, 9'h007, 0, 0, 9'h000);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    checkOutput("t3_two_ops", 9'h007, 9'h003, 2, 0, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 9'h000, 0, 1, 9'h00A);
`ifdef OPBUF_RESULT_PUSH_EN
    checkOutput("t3_result", 9'h00A, 9'h000, 1, 0, 0, 8'h0A, 0, 0);
    applyStimulus(0, 0, 9'h000, 0, 0, 9'h000);
    checkOutput("t3_result_hold", 9'h00A, 9'h000, 1, 0, 0, 8'h0A, 0, 0);
`else
    checkOutput("t3_result", 9'h000, 9'h000, 0, 0, 1, 8'h0A, 0, 0);
    applyStimulus(0, 0, 9'h000, 0, 0, 9'h000);
    checkOutput("t3_result_hold", 9'h000, 9'h000, 0, 0, 1, 8'h0A, 0, 0);
`endif

    // Priority between simultaneous events
    applyStimulus(1, 0, 9'h000, 0, 0, 9'h000);
    checkOutput("t4_clear", 9'h000, 9'h000, 0, 0, 1, 8'h00, 0, 0);
    applyStimulus(0, 1, 9'h004, 1, 0, 9'h000);
    checkOutput("t4_store_beats_enter", 9'h000, 9'h000, 0, 0, 1, 8'h04, 0, 0);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    checkOutput("t4_entry_was_4", 9'h004, 9'h000, 1, 0, 0, 8'h00, 0, 0);
    applyStimulus(1, 1, 9'h006, 0, 0, 9'h000);
    checkOutput("t4_clear_beats_store", 9'h000, 9'h000, 0, 0, 1, 8'h00, 0, 0);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    checkOutput("t4_entry_was_0", 9'h000, 9'h000, 1, 0, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 9'h000, 1, 1, 9'h077);
    checkOutput("t4_enter_beats_result", 9'h000, 9'h000, 2, 0, 0, 8'h00, 0, 0);

    // Result underflow and negative zero
    applyStimulus(1, 0, 9'h000, 0, 0, 9'h000);
    applyStimulus(0, 1, 9'h103, 0, 0, 9'h000);
    checkOutput("t5_store_neg3", 9'h000, 9'h000, 0, 0, 1, 8'h03, 1, 0);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    checkOutput("t5_push_neg3", 9'h103, 9'h000, 1, 0, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 9'h000, 0, 1, 9'h1FF);
`ifdef OPBUF_RESULT_PUSH_EN
    checkOutput("t5_underflow", 9'h103, 9'h000, 1, 0, 0, 8'hFF, 1, 1);
    applyStimulus(0, 1, 9'h100, 0, 0, 9'h000);
    checkOutput("t5_neg_zero", 9'h103, 9'h000, 1, 0, 0, 8'h00, 1, 1);
`else
    checkOutput("t5_underflow", 9'h000, 9'h000, 0, 0, 1, 8'hFF, 1, 1);
    applyStimulus(0, 1, 9'h100, 0, 0, 9'h000);
    checkOutput("t5_neg_zero", 9'h000, 9'h000, 0, 0, 1, 8'h00, 1, 1);
`endif
    applyStimulus(1, 0, 9'h000, 0, 0, 9'h000);
    checkOutput("t5_clear_err", 9'h000, 9'h000, 0, 0, 1, 8'h00, 0, 0);

    // Mid-operation asynchronous reset
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, 9'(i), 0, 0, 9'h000);
      applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    end
    checkOutput("t6_four_pushed", 9'h004, 9'h003, 4, 1, 0, 8'h00, 0, 0);
    applyStimulus(0, 0, 9'h000, 0, 1, 9'h055);
`ifdef OPBUF_RESULT_PUSH_EN
    checkOutput("t6_result", 9'h055, 9'h002, 3, 0, 0, 8'h55, 0, 0);
`else
    checkOutput("t6_result", 9'h000, 9'h000, 0, 0, 1, 8'h55, 0, 0);
`endif
    @(negedge clk);
    #2;
    nrst = 1'b0;
    #1;
    compareSnap("t6_async_reset", zeroSnap);
    @(negedge clk);
    #2;
    nrst = 1'b1;
    applyStimulus(0, 1, 9'h012, 0, 0, 9'h000);
    checkOutput("t6_store_after_reset", 9'h000, 9'h000, 0, 0, 1, 8'h12, 0, 0);
    applyStimulus(0, 0, 9'h000, 1, 0, 9'h000);
    checkOutput("t6_push_after_reset", 9'h012, 9'h000, 1, 0, 0, 8'h00, 0, 0);

    // Let the monitor drain the scoreboard, with a bounded wait.
    for (int i = 0; i < 20 && expQ.size() > 0; i++) begin
      @(negedge clk);
    end
    #1;
    if (expQ.size() > 0) begin
      checkCount++;
      $display("[TB] FAIL scoreboard_drain: %0d expectations left, want 0", expQ.size());
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
